// File: rtl/operand_fetch_stage_if.sv
// Operand-fetch stage bus: upstream and downstream handshakes,
// register file read port, writeback snoop and load-use inputs.
interface operand_fetch_stage_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic [31:0]            in_pc;
  logic [4:0]             rf_raddr1;
  logic [4:0]             rf_raddr2;
  logic [31:0]            rf_rdata1;
  logic [31:0]            rf_rdata2;
  logic                   wb_we;
  logic [4:0]             wb_waddr;
  logic [31:0]            wb_wdata;
  logic                   ex_load_pending;
  logic [4:0]             ex_load_rd;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [5:0]             out_opcode;
  logic [5:0]             out_funct;
  logic [4:0]             out_shamt;
  logic [31:0]            out_rs_val;
  logic [31:0]            out_rt_val;
  logic [31:0]            out_imm;
  logic [4:0]             out_dest;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output in_valid, in_instr, in_pc,
    output rf_rdata1, rf_rdata2,
    output wb_we, wb_waddr, wb_wdata,
    output ex_load_pending, ex_load_rd,
    output flush, out_ready,
    input  in_ready, rf_raddr1, rf_raddr2,
    input  out_valid, out_pc, out_opcode,
    input  out_funct, out_shamt, out_rs_val,
    input  out_rt_val, out_imm, out_dest,
    input  stall_cycles
  );

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  rf_rdata1, rf_rdata2,
    input  wb_we, wb_waddr, wb_wdata,
    input  ex_load_pending, ex_load_rd,
    input  flush, out_ready,
    output in_ready, rf_raddr1, rf_raddr2,
    output out_valid, out_pc, out_opcode,
    output out_funct, out_shamt, out_rs_val,
    output out_rt_val, out_imm, out_dest,
    output stall_cycles
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch stage: rf addressing, writeback bypass,
// load-use interlock and a registered bundle toward EX.
module operand_fetch_stage #(
  parameter int STALL_CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_fetch_stage_if.slave bus
);

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        rs_used;
  logic        rt_used;
  logic        hazard;
  logic        accept;
  logic [4:0]  dest;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  logic                   out_valid_q, out_valid_d;
  logic [31:0]            out_pc_q, out_pc_d;
  logic [5:0]             out_opcode_q, out_opcode_d;
  logic [5:0]             out_funct_q, out_funct_d;
  logic [4:0]             out_shamt_q, out_shamt_d;
  logic [31:0]            out_rs_val_q, out_rs_val_d;
  logic [31:0]            out_rt_val_q, out_rt_val_d;
  logic [31:0]            out_imm_q, out_imm_d;
  logic [4:0]             out_dest_q, out_dest_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  assign opcode = bus.in_instr[31:26];
  assign rs     = bus.in_instr[25:21];
  assign rt     = bus.in_instr[20:16];
  assign rd     = bus.in_instr[15:11];

  assign bus.rf_raddr1 = rs;
  assign bus.rf_raddr2 = rt;

  // The rf write lands next edge, so snoop writeback this cycle
  function automatic logic [31:0] fwd(
    input logic [4:0]  src,
    input logic [31:0] rf,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd
  );
    if (we && wa != 5'd0 && wa == src) return wd;
    if (src == 5'd0) return 32'd0;
    return rf;
  endfunction

  // Decode source usage and destination register
  always_comb begin
    rs_used = !(opcode == 6'h02 || opcode == 6'h03);
    rt_used = (opcode == 6'h00) || (opcode == 6'h04) ||
              (opcode == 6'h05) || (opcode == 6'h2B);
    dest = 5'd0;
    unique case (1'b1)
      (opcode == 6'h00):                          dest = rd;
      (opcode[5:3] == 3'b001 || opcode == 6'h23): dest = rt;
      (opcode == 6'h03):                          dest = 5'd31;
      default:                                    dest = 5'd0;
    endcase
  end

  // Load-use interlock and handshake
  always_comb begin
    hazard = bus.ex_load_pending && bus.ex_load_rd != 5'd0 &&
             ((rs_used && bus.ex_load_rd == rs) ||
              (rt_used && bus.ex_load_rd == rt));
    bus.in_ready = !hazard && (!out_valid_q || bus.out_ready) &&
                   !bus.flush;
    accept = bus.in_valid && bus.in_ready;
    rs_fwd = fwd(rs, bus.rf_rdata1, bus.wb_we,
                 bus.wb_waddr, bus.wb_wdata);
    rt_fwd = fwd(rt, bus.rf_rdata2, bus.wb_we,
                 bus.wb_waddr, bus.wb_wdata);
  end

  // Next-state for bundle register and stall counter
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_opcode_d = out_opcode_q;
    out_funct_d  = out_funct_q;
    out_shamt_d  = out_shamt_q;
    out_rs_val_d = out_rs_val_q;
    out_rt_val_d = out_rt_val_q;
    out_imm_d    = out_imm_q;
    out_dest_d   = out_dest_q;
    stall_d      = stall_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_pc_d     = bus.in_pc;
      out_opcode_d = opcode;
      out_funct_d  = bus.in_instr[5:0];
      out_shamt_d  = bus.in_instr[10:6];
      out_rs_val_d = rs_fwd;
      out_rt_val_d = rt_fwd;
      out_imm_d    = {{16{bus.in_instr[15]}},
                      bus.in_instr[15:0]};
      out_dest_d   = dest;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (bus.in_valid && hazard && !bus.flush &&
        stall_q != '1)
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_opcode_q <= '0;
      out_funct_q  <= '0;
      out_shamt_q  <= '0;
      out_rs_val_q <= '0;
      out_rt_val_q <= '0;
      out_imm_q    <= '0;
      out_dest_q   <= '0;
      stall_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_opcode_q <= out_opcode_d;
      out_funct_q  <= out_funct_d;
      out_shamt_q  <= out_shamt_d;
      out_rs_val_q <= out_rs_val_d;
      out_rt_val_q <= out_rt_val_d;
      out_imm_q    <= out_imm_d;
      out_dest_q   <= out_dest_d;
      stall_q      <= stall_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_opcode   = out_opcode_q;
  assign bus.out_funct    = out_funct_q;
  assign bus.out_shamt    = out_shamt_q;
  assign bus.out_rs_val   = out_rs_val_q;
  assign bus.out_rt_val   = out_rt_val_q;
  assign bus.out_imm      = out_imm_q;
  assign bus.out_dest     = out_dest_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, bypass,
// load-use, backpressure, flush and decode vectors.
module tb_operand_fetch_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  operand_fetch_stage_if #(.STALL_CNT_W(16)) bus ();

  operand_fetch_stage #(.STALL_CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] add_i(
    input logic [4:0] s, input logic [4:0] t,
    input logic [4:0] d
  );
    return {6'h00, s, t, d, 5'd0, 6'h20};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.rf_rdata1 = '0;
    bus.rf_rdata2 = '0;
    bus.wb_we = 1'b0;
    bus.wb_waddr = '0;
    bus.wb_wdata = '0;
    bus.ex_load_pending = 1'b0;
    bus.ex_load_rd = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    rst_n = 1'b1;

    // bypass from writeback
    bus.in_instr = add_i(5'd5, 5'd6, 5'd7);
    bus.in_pc = 32'h100;
    bus.rf_rdata1 = 32'h11;
    bus.rf_rdata2 = 32'h22;
    bus.wb_we = 1'b1;
    bus.wb_waddr = 5'd5;
    bus.wb_wdata = 32'hDEAD;
    bus.in_valid = 1'b1;
    #1;
    chk("raddr1", 32'(bus.rf_raddr1), 32'd5);
    chk("raddr2", 32'(bus.rf_raddr2), 32'd6);
    chk("rdy_idle", 32'(bus.in_ready), 32'd1);
    tick();
    chk("byp_valid", 32'(bus.out_valid), 32'd1);
    chk("byp_rs", bus.out_rs_val, 32'hDEAD);
    chk("byp_rt", bus.out_rt_val, 32'h22);
    chk("byp_dest", 32'(bus.out_dest), 32'd7);
    chk("byp_funct", 32'(bus.out_funct), 32'h20);
    chk("byp_pc", bus.out_pc, 32'h100);

    bus.wb_waddr = 5'd0;
    bus.in_pc = 32'h104;
    #1;
    chk("rdy_b2b", 32'(bus.in_ready), 32'd1);
    tick();
    chk("nobyp_rs", bus.out_rs_val, 32'h11);
    chk("nobyp_pc", bus.out_pc, 32'h104);

    // load-use on rt
    bus.wb_we = 1'b0;
    bus.ex_load_pending = 1'b1;
    bus.ex_load_rd = 5'd8;
    bus.in_instr = add_i(5'd1, 5'd8, 5'd9);
    bus.in_pc = 32'h108;
    bus.rf_rdata1 = 32'h1;
    bus.rf_rdata2 = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lu_rdy", 32'(bus.in_ready), 32'd0);
      tick();
    end
    chk("lu_stall", 32'(bus.stall_cycles), 32'd3);
    chk("lu_drain", 32'(bus.out_valid), 32'd0);
    bus.ex_load_pending = 1'b0;
    #1;
    chk("lu_rel", 32'(bus.in_ready), 32'd1);
    tick();
    chk("lu_valid", 32'(bus.out_valid), 32'd1);
    chk("lu_dest", 32'(bus.out_dest), 32'd9);
    chk("lu_rt", bus.out_rt_val, 32'h8);

    // backpressure, then ADDI with negative imm
    bus.out_ready = 1'b0;
    bus.in_instr = {6'h08, 5'd2, 5'd3, 16'hFFFF};
    bus.in_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
      tick();
      chk("bp_pc", bus.out_pc, 32'h108);
      chk("bp_dest", 32'(bus.out_dest), 32'd9);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel", 32'(bus.in_ready), 32'd1);
    tick();
    chk("addi_pc", bus.out_pc, 32'h200);
    chk("addi_dest", 32'(bus.out_dest), 32'd3);
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    chk("addi_rs", bus.out_rs_val, 32'h1);
    chk("addi_op", 32'(bus.out_opcode), 32'h08);

    // flush kills bundle and does not consume
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    bus.in_instr = {6'h03, 5'd8, 21'd0};
    bus.in_pc = 32'h300;
    #1;
    chk("fl_rdy", 32'(bus.in_ready), 32'd0);
    tick();
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_stall", 32'(bus.stall_cycles), 32'd3);

    // JAL: rs field matches pending load, but rs unused
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.ex_load_pending = 1'b1;
    bus.ex_load_rd = 5'd8;
    #1;
    chk("jal_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    chk("jal_valid", 32'(bus.out_valid), 32'd1);
    chk("jal_dest", 32'(bus.out_dest), 32'd31);
    chk("jal_pc", bus.out_pc, 32'h300);
    chk("jal_stall", 32'(bus.stall_cycles), 32'd3);

    // $zero source ignores rf data and wb to r0
    bus.ex_load_pending = 1'b0;
    bus.in_instr = add_i(5'd0, 5'd4, 5'd0);
    bus.in_pc = 32'h304;
    bus.rf_rdata1 = 32'h55;
    bus.rf_rdata2 = 32'h44;
    bus.wb_we = 1'b1;
    bus.wb_waddr = 5'd0;
    bus.wb_wdata = 32'h99;
    tick();
    chk("zero_rs", bus.out_rs_val, 32'd0);
    chk("zero_rt", bus.out_rt_val, 32'h44);
    chk("zero_dest", 32'(bus.out_dest), 32'd0);

    // asynchronous reset with a valid bundle held
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    chk("pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_stall", 32'(bus.stall_cycles), 32'd0);
    chk("arst_pc", bus.out_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
